// File: rtl/sipo_ctrl_pkg.sv
// Shared types and constants for the serial-in/parallel-out frame controller.
package sipo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } sipo_state_t;

  localparam int SIPO_WIDTH_DEF = 4;

endpackage

// File: rtl/sipo_shift_reg.sv
// MSB-insert right-shift register; a clear coincident with a shift starts a fresh word.
module sipo_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr && shift_en) begin
      q <= {din, {(WIDTH-1){1'b0}}};
    end else if (clr) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {din, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frames serial bit strobes into WIDTH-bit words presented on a valid/ready output.
module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sin_valid,
  input  logic             sin,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_abort,
  output logic             overrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sipo_state_t      state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] shifted;
  logic             last;
  logic             frame_begin, clr, shift_en;
  logic             capture, release_word, abort_set, drop;

  sipo_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .shift_en (shift_en),
    .din      (sin),
    .q        (q)
  );

  assign shifted = {sin, q[WIDTH-1:1]};
  assign last    = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (start) state_next = SHIFT;
               else if (sin_valid && last) state_next = HOLD;
      HOLD:    if (out_ready) state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A start accepted in HOLD only on the handshake cycle gives gapless back-to-back frames.
  always_comb begin
    frame_begin  = start && ((state == IDLE) || (state == SHIFT) ||
                             ((state == HOLD) && out_ready));
    clr          = frame_begin;
    shift_en     = sin_valid && (frame_begin || (state == SHIFT));
    capture      = (state == SHIFT) && !start && sin_valid && last;
    release_word = (state == HOLD) && out_ready;
    abort_set    = (state == SHIFT) && start;
    drop         = (state == HOLD) && !out_ready && (start || sin_valid);
    cnt_next     = cnt;
    if (frame_begin)   cnt_next = sin_valid ? CW'(1) : '0;
    else if (shift_en) cnt_next = last ? '0 : cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      frame_abort <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      busy        <= (state_next == SHIFT);
      frame_abort <= abort_set;
      if (drop) overrun <= 1'b1;
      if (capture) begin
        out_data  <= shifted;
        out_valid <= 1'b1;
      end else if (release_word) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl at WIDTH=4 with hand-computed expectations.
module tb_sipo_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, sin_valid, sin, out_ready;
  logic [3:0] out_data;
  logic       out_valid, busy, frame_abort, overrun;
  int         n_checks = 0;
  int         n_fail   = 0;

  sipo_frame_ctrl #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sin_valid   (sin_valid),
    .sin         (sin),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .frame_abort (frame_abort),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of inputs, then let the edge happen.
  task automatic drive(input logic st, input logic v, input logic b);
    start = st; sin_valid = v; sin = b;
    step();
  endtask

  task automatic check_all(input string tag, input logic [3:0] d, input logic v,
                           input logic bz, input logic ab, input logic ov);
    check({tag, ".data"},  32'(out_data),    32'(d));
    check({tag, ".valid"}, 32'(out_valid),   32'(v));
    check({tag, ".busy"},  32'(busy),        32'(bz));
    check({tag, ".abort"}, 32'(frame_abort), 32'(ab));
    check({tag, ".ovr"},   32'(overrun),     32'(ov));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sin_valid = 1'b0; sin = 1'b0; out_ready = 1'b1;
    step(); step();
    check_all("reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Basic frame 1,0,1,1 -> 4'b1101
    drive(1, 1, 1); check_all("basic.b0", 4'h0, 0, 1, 0, 0);
    drive(0, 1, 0);
    drive(0, 1, 1); check("basic.b2.valid", 32'(out_valid), 32'd0);
    drive(0, 1, 1); check_all("basic.word", 4'hD, 1, 0, 0, 0);
    drive(0, 0, 0); check_all("basic.after", 4'hD, 0, 0, 0, 0);

    // Backpressure: frame 0,0,1,0 -> 4'b0100 held, then overrun
    out_ready = 1'b0;
    drive(1, 1, 0); drive(0, 1, 0); drive(0, 1, 1); drive(0, 1, 0);
    check_all("bp.word", 4'h4, 1, 0, 0, 0);
    for (int unsigned i = 0; i < 5; i++) begin
      drive(0, 0, 0);
      check_all("bp.hold", 4'h4, 1, 0, 0, 0);
    end
    drive(0, 1, 1); check_all("bp.drop1", 4'h4, 1, 0, 0, 1);
    drive(0, 1, 0); check_all("bp.drop2", 4'h4, 1, 0, 0, 1);
    out_ready = 1'b1;
    drive(0, 0, 0); check_all("bp.release", 4'h4, 0, 0, 0, 1);

    // Restart mid-frame: 1,1 then start+0, 1,1,1 -> 4'b1110, overrun still sticky
    drive(1, 1, 1); drive(0, 1, 1);
    check("rs.noabort", 32'(frame_abort), 32'd0);
    drive(1, 1, 0); check_all("rs.abort", 4'h4, 0, 1, 1, 1);
    drive(0, 1, 1); check_all("rs.b1", 4'h4, 0, 1, 0, 1);
    drive(0, 1, 1); check("rs.b2.abort", 32'(frame_abort), 32'd0);
    drive(0, 1, 1); check_all("rs.word", 4'hE, 1, 0, 0, 1);
    drive(0, 0, 0); check("rs.release", 32'(out_valid), 32'd0);

    // Back-to-back: 0xA (0,1,0,1) then start on the handshake for 0x5 (1,0,1,0)
    drive(1, 1, 0); drive(0, 1, 1); drive(0, 1, 0); drive(0, 1, 1);
    check_all("b2b.wordA", 4'hA, 1, 0, 0, 1);
    drive(1, 1, 1); check_all("b2b.hs", 4'hA, 0, 1, 0, 1);
    drive(0, 1, 0);
    drive(0, 1, 1); check("b2b.mid.valid", 32'(out_valid), 32'd0);
    drive(0, 1, 0); check_all("b2b.word5", 4'h5, 1, 0, 0, 1);
    drive(0, 0, 0); check("b2b.release", 32'(out_valid), 32'd0);

    // Reset mid-frame, then 0,1,1,0 -> 4'b0110 with overrun cleared
    drive(1, 1, 1); drive(0, 1, 0);
    rst = 1'b1;
    drive(0, 0, 0); check_all("rstmid", 4'h0, 0, 0, 0, 0);
    rst = 1'b0;
    drive(1, 1, 0); drive(0, 1, 1); drive(0, 1, 1); drive(0, 1, 0);
    check_all("rstmid.word", 4'h6, 1, 0, 0, 0);
    drive(0, 0, 0);

    // Strobes in IDLE ignored; gapped 1,0,1,1 -> 4'b1101
    drive(0, 1, 1); drive(0, 1, 0);
    check_all("idle.ign", 4'h6, 0, 0, 0, 0);
    drive(1, 1, 1); drive(0, 0, 0);
    drive(0, 1, 0); drive(0, 0, 1); drive(0, 0, 0);
    drive(0, 1, 1); drive(0, 0, 0);
    check_all("gap.mid", 4'h6, 0, 1, 0, 0);
    drive(0, 1, 1); check_all("gap.word", 4'hD, 1, 0, 0, 0);
    drive(0, 0, 0); check("gap.release", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_frame_ctrl.md
# sipo_frame_ctrl

Sequences a serial-in/parallel-out shift datapath into framed parallel words. It detects a frame start, counts `WIDTH` serial bit strobes, and presents the assembled word on a valid/ready output. It holds the word until a consumer accepts it and flags bits lost while the word is held. It sits between a serial bit source (bit strobe plus data) and a parallel word consumer.

## Interface
- `WIDTH`, 4, bits per frame; legal range 2..32.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  frame-start pulse.
- `sin_valid`  in  1  serial bit strobe; `sin` is sampled only when this is 1.
- `sin`  in  1  serial data bit.
- `out_data`  out  WIDTH  assembled word.
- `out_valid`  out  1  word available.
- `out_ready`  in  1  consumer accepts the word.
- `busy`  out  1  frame in progress (state SHIFT).
- `frame_abort`  out  1  one-cycle pulse when a frame in progress is restarted.
- `overrun`  out  1  sticky flag: a bit or start was dropped while holding a word.

## Operation
- **Reset values:** state IDLE, bit count 0, shift register 0, `out_data` 0, `out_valid` 0, `busy` 0, `frame_abort` 0, `overrun` 0.
- **Shift rule:** each accepted bit enters the MSB and the rest shift right by one. The first bit of a frame therefore ends at `out_data[0]` and the last at `out_data[WIDTH-1]`.
- **Bit counter:** width `$clog2(WIDTH)`, values 0..WIDTH-1, cleared on every frame start. It never wraps past WIDTH-1; reaching WIDTH-1 with a strobe completes the frame.
- **IDLE:**
  - `start`=1 → SHIFT; counter cleared.
  - If `sin_valid`=1 in the same cycle, that bit is bit 0 and the counter becomes 1.
  - `sin_valid` without `start` is ignored, with no flag.
- **SHIFT:**
  - `sin_valid`=1 shifts `sin` in and increments the counter.
  - A strobe while the counter is WIDTH-1 copies the completed word to `out_data`, asserts `out_valid` and goes to HOLD.
  - `start`=1 in SHIFT restarts the frame: counter cleared, shift register cleared, `frame_abort` pulses for one cycle. A coincident `sin_valid` counts as bit 0 of the new frame.
- **HOLD:**
  - `out_data` and `out_valid` stay stable until `out_valid && out_ready`.
  - `sin_valid` or `start` while `out_ready`=0 is dropped and sets `overrun`.
  - On handshake with `start`=0 → IDLE.
  - On handshake with `start`=1 → SHIFT with the start processed as in IDLE (back-to-back frames, no dropped cycle).
  - On handshake with `sin_valid`=1 and `start`=0, the bit is dropped silently.
- **`overrun`:** stays set until `rst`; it is not cleared by handshakes.
- **`busy`:** 1 exactly while in SHIFT.
- **Mid-operation reset:** from any state, `rst` returns everything to the reset values on the next edge. A partial word is discarded and is never presented.
- **Priority within a cycle:** `rst` > handshake > `start` > `sin_valid`.

## Timing
- **Output latency:** `out_valid` rises on the same edge that samples the final bit. The word is visible in the cycle after the last strobe.
- **Minimum frame:** WIDTH cycles from the start/first bit to `out_valid`, with `sin_valid` held high continuously.
- **Handshake:** `out_valid` falls on the edge that samples `out_valid && out_ready`.
- **Combinational paths:** `out_ready` has no combinational path to any output; all outputs are registered.
- **`frame_abort`:** registered; high in the cycle after the restarting `start`.
- **Throughput:** with `out_ready` tied high and continuous strobes, one word every WIDTH cycles.

## Structure
- **Package `sipo_ctrl_pkg`:** state enum `{IDLE, SHIFT, HOLD}` (2-bit encoding) and the default-width constant `SIPO_WIDTH_DEF = 4`.
- **Sub-module `sipo_shift_reg`:** parameterised datapath with ports `clk`, `rst`, `clr`, `shift_en`, `din`, `q[WIDTH-1:0]`, and MSB-insert right shift. The controller owns the FSM, the counter, the output register and the flags.
- **Size:** about 200 lines of RTL in total.

## Test plan
- **Basic frame:** WIDTH=4, `out_ready`=1; `start`+`sin_valid` with bits 1,0,1,1 on consecutive cycles → `out_data`=4'b1101 and `out_valid` high for one cycle, starting the cycle after the 4th bit.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after a frame of 0,0,1,0 → `out_data`=4'b0100 stable throughout. Then strobe two bits while holding → `overrun`=1 sticky, and `out_data` is unchanged.
- **Restart mid-frame:**
  - Send bits 1,1 then `start` with bit 0, followed by 1,1,1 → `frame_abort` pulses once.
  - `out_data`=4'b1110.
- **Back-to-back frames:** assert `start` in the same cycle as the handshake → the second frame is captured without a gap; two words arrive 4 cycles apart (0xA, then 0x5).
- **Reset mid-frame:** `rst` after 2 of 4 bits → all outputs 0 on the next cycle. A subsequent full frame of 0,1,1,0 → 4'b0110 with `overrun`=0.
- **Gapped strobes:** insert idle cycles between bits with `sin_valid`=0 → the same word as the gapless case. Strobes in IDLE without `start` are ignored and leave `overrun` at 0.
